// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared state, mode and seed definitions for the LED sequencer.
package led_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [1:0]  MODE_ROT_L    = 2'd0;
    localparam logic [1:0]  MODE_ROT_R    = 2'd1;
    localparam logic [1:0]  MODE_BOUNCE   = 2'd2;
    localparam logic [1:0]  MODE_BOUNCE_M = 2'd3;
    localparam logic [15:0] SEED_LSB      = 16'h0001;
    localparam logic [15:0] SEED_MSB      = 16'h8000;
    localparam logic        DIR_UP        = 1'b1;

    function automatic logic is_bounce(logic [1:0] m);
        return m == MODE_BOUNCE || m == MODE_BOUNCE_M;
    endfunction

    function automatic logic starts_msb(logic [1:0] m);
        return m == MODE_ROT_R || m == MODE_BOUNCE_M;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: control/feedback bundle between the sequencer and the LED datapath.
interface led_seq_ctrl_if;

    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] led_in;
    logic        load;
    logic [15:0] load_val;
    logic        shift_en;
    logic        shift_dir;
    logic        busy;
    logic        done;
    logic [7:0]  lap_cnt;

    modport master (
        output start, stop, mode, led_in,
        input  load, load_val, shift_en, shift_dir, busy, done, lap_cnt
    );

    modport slave (
        input  start, stop, mode, led_in,
        output load, load_val, shift_en, shift_dir, busy, done, lap_cnt
    );

endinterface

// File: rtl/led_seq_ctrl_tick_gen.sv
// tick_gen: one-cycle tick every TICK_MAX+1 enabled cycles, held at zero while clr.
module tick_gen #(
    parameter int TICK_MAX = 50_000_000,
    parameter int TICK_W   = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [TICK_W-1:0] CNT_MAX = TICK_W'(TICK_MAX);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    assign tick = en && cnt_q == CNT_MAX;

    always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: run-mode FSM producing load/shift controls for the rotating-LED register.
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int         TICK_MAX = 50_000_000,
    parameter int         TICK_W   = 26,
    parameter logic [7:0] LAPS     = 8'd4
) (
    input logic          clk,
    input logic          rst_n,
    led_seq_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic        bounce_q, bounce_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  lap_cnt_q, lap_cnt_d;
    logic [15:0] load_val_q, load_val_d;
    logic        load_q, load_d;
    logic        shift_en_q, shift_en_d;
    logic        shift_dir_q, shift_dir_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick, hit, lap;

    // busy_q is exactly "in LOAD or RUN", so it doubles as the tick counter enable
    tick_gen #(.TICK_MAX(TICK_MAX), .TICK_W(TICK_W)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!busy_q),
        .en   (busy_q),
        .tick (tick)
    );

    assign hit = shift_dir_q ? bus.led_in[15] : bus.led_in[0];

    always_comb begin
        state_d     = state_q;
        bounce_d    = bounce_q;
        step_d      = step_q;
        lap_cnt_d   = lap_cnt_q;
        load_val_d  = load_val_q;
        shift_dir_d = shift_dir_q;
        shift_en_d  = 1'b0;
        lap         = 1'b0;
        case (state_q)
            IDLE: if (bus.start && !bus.stop) begin
                state_d     = LOAD;
                bounce_d    = is_bounce(bus.mode);
                step_d      = '0;
                lap_cnt_d   = '0;
                load_val_d  = starts_msb(bus.mode) ? SEED_MSB : SEED_LSB;
                shift_dir_d = starts_msb(bus.mode) ? ~DIR_UP : DIR_UP;
            end
            LOAD: state_d = bus.stop ? IDLE : RUN;
            RUN: if (bus.stop) begin
                state_d = IDLE;
            end else if (tick) begin
                shift_en_d = 1'b1;
                // bounce turns around before shifting, so this tick's shift uses the new direction
                if (bounce_q) begin
                    lap         = hit;
                    shift_dir_d = hit ? ~shift_dir_q : shift_dir_q;
                end else begin
                    lap    = step_q == 4'hF;
                    step_d = step_q + 1'b1;
                end
                if (lap) begin
                    lap_cnt_d = &lap_cnt_q ? lap_cnt_q : lap_cnt_q + 1'b1;
                    state_d   = (LAPS != 8'd0 && lap_cnt_d == LAPS) ? DONE : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        load_d = state_d == LOAD;
        busy_d = state_d == LOAD || state_d == RUN;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bounce_q    <= 1'b0;
            step_q      <= '0;
            lap_cnt_q   <= '0;
            load_val_q  <= '0;
            load_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            shift_dir_q <= DIR_UP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bounce_q    <= bounce_d;
            step_q      <= step_d;
            lap_cnt_q   <= lap_cnt_d;
            load_val_q  <= load_val_d;
            load_q      <= load_d;
            shift_en_q  <= shift_en_d;
            shift_dir_q <= shift_dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.load      = load_q;
    assign bus.load_val  = load_val_q;
    assign bus.shift_en  = shift_en_q;
    assign bus.shift_dir = shift_dir_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.lap_cnt   = lap_cnt_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed bench with a modelled LED shift register on led_in.
module tb_led_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_seq_ctrl_if bus();
    led_seq_ctrl_if bus0();

    led_seq_ctrl #(.TICK_MAX(3), .TICK_W(2), .LAPS(8'd2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    led_seq_ctrl #(.TICK_MAX(3), .TICK_W(2), .LAPS(8'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    logic [15:0] led = '0, led0 = '0;

    function automatic logic [15:0] shf(logic [15:0] x, logic d);
        return d ? {x[14:0], x[15]} : {x[0], x[15:1]};
    endfunction

    always @(posedge clk) begin
        if (bus.load) led <= bus.load_val;
        else if (bus.shift_en) led <= shf(led, bus.shift_dir);
        if (bus0.load) led0 <= bus0.load_val;
        else if (bus0.shift_en) led0 <= shf(led0, bus0.shift_dir);
    end

    assign bus.led_in  = led;
    assign bus0.led_in = led0;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // expected LED value seen at the k-th shift pulse (before that shift lands)
    function automatic logic [15:0] exp_led(logic [1:0] m, int k);
        int j, p;
        j = k - 1;
        p = m[1] ? (j <= 15 ? j : 30 - j) : j % 16;
        if (m[0]) p = 15 - p;
        return 16'h1 << p;
    endfunction

    function automatic logic exp_dir(logic [1:0] m, int k);
        return m[1] ? ((k < 16 || k >= 31) ^ m[0]) : !m[0];
    endfunction

    function automatic logic [7:0] exp_lap(logic [1:0] m, int k);
        return m[1] ? ((k >= 31) ? 8'd2 : (k >= 16) ? 8'd1 : 8'd0) : 8'(k / 16);
    endfunction

    task automatic wait_shifts(input int n, input string tag);
        int k = 0;
        for (int c = 0; c < n * 4 + 20 && k < n; c++) begin
            cyc();
            if (bus.shift_en) k++;
        end
        chk({tag, "_reach"}, k, n);
    endtask

    task automatic run(input logic [1:0] m, input int total, input int inj, input string tag);
        int k = 0, last = 0;
        bit fin = 0;
        bus.mode = m;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk({tag, "_load"}, bus.load, 1);
        chk({tag, "_seed"}, bus.load_val, exp_led(m, 1));
        chk({tag, "_dir0"}, bus.shift_dir, exp_dir(m, 1));
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_noshift"}, bus.shift_en, 0);
        for (int c = 1; c <= 200 && !fin; c++) begin
            cyc();
            if (bus.shift_en) begin
                k++;
                chk({tag, "_gap"}, c - last, 4);
                last = c;
                chk({tag, "_led"}, bus.led_in, exp_led(m, k));
                chk({tag, "_dir"}, bus.shift_dir, exp_dir(m, k));
                chk({tag, "_lap"}, bus.lap_cnt, exp_lap(m, k));
                chk({tag, "_load_x"}, bus.load, 0);
            end
            chk({tag, "_done"}, bus.done, bus.shift_en && k == total);
            fin = bus.done;
            bus.start = (k == inj && c == last + 1);
            bus.mode = bus.start ? ~m : m;
        end
        chk({tag, "_shifts"}, k, total);
        chk({tag, "_busy_end"}, bus.busy, 0);
        cyc();
        chk({tag, "_done_end"}, bus.done, 0);
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_lap_hold"}, bus.lap_cnt, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bad;
        bit seen_done;
        bus.start = 0; bus.stop = 0; bus.mode = 0;
        bus0.start = 0; bus0.stop = 0; bus0.mode = 0;
        cyc(2);
        chk("rst_load", bus.load, 0);
        chk("rst_val", bus.load_val, 0);
        chk("rst_shift", bus.shift_en, 0);
        chk("rst_dir", bus.shift_dir, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_lap", bus.lap_cnt, 0);
        rst_n = 1'b1;
        cyc();

        run(2'd0, 32, -1, "rotl");
        run(2'd1, 32, -1, "rotr");
        run(2'd2, 31, -1, "bounce");
        run(2'd3, 31, -1, "bouncem");
        run(2'd0, 32, 5, "inj");

        // stop on a tick cycle after the first lap
        bus.mode = 2'd0; bus.start = 1; cyc(); bus.start = 0;
        wait_shifts(17, "stop");
        cyc(3);
        chk("stop_pre", bus.shift_en, 0);
        bus.stop = 1;
        cyc();
        bus.stop = 0;
        chk("stop_shift", bus.shift_en, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_done", bus.done, 0);
        chk("stop_lap", bus.lap_cnt, 1);
        bad = 0;
        repeat (10) begin
            cyc();
            if (bus.shift_en || bus.done || bus.busy) bad++;
        end
        chk("stop_quiet", bad, 0);
        chk("stop_lap_hold", bus.lap_cnt, 1);

        // start together with stop in IDLE
        bus.start = 1; bus.stop = 1; cyc(); bus.start = 0; bus.stop = 0;
        chk("ss_load", bus.load, 0);
        chk("ss_busy", bus.busy, 0);
        cyc(2);
        chk("ss_busy2", bus.busy, 0);

        // async reset mid-run after the bounce turned around
        bus.mode = 2'd2; bus.start = 1; cyc(); bus.start = 0;
        wait_shifts(17, "mrst");
        chk("mrst_pre_dir", bus.shift_dir, 0);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("mrst_load", bus.load, 0);
        chk("mrst_val", bus.load_val, 0);
        chk("mrst_shift", bus.shift_en, 0);
        chk("mrst_dir", bus.shift_dir, 1);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        chk("mrst_lap", bus.lap_cnt, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("mrst_idle", bus.busy, 0);
        bus.mode = 2'd1; bus.start = 1; cyc(); bus.start = 0;
        chk("mrst_restart", bus.load, 1);
        chk("mrst_restart_val", bus.load_val, 16'h8000);
        bus.stop = 1; cyc(); bus.stop = 0;
        chk("mrst_abort", bus.busy, 0);

        // unlimited laps saturate the lap counter
        bus0.mode = 2'd0; bus0.start = 1; cyc(); bus0.start = 0;
        chk("inf_load", bus0.load, 1);
        k = 0;
        seen_done = 0;
        for (int c = 0; c < 17000 && k < 4112; c++) begin
            cyc();
            if (bus0.done) seen_done = 1;
            if (bus0.shift_en) begin
                k++;
                if (k == 4079) chk("inf_lap_fe", bus0.lap_cnt, 8'hFE);
                if (k == 4080) chk("inf_lap_ff", bus0.lap_cnt, 8'hFF);
                if (k == 4096) chk("inf_lap_sat", bus0.lap_cnt, 8'hFF);
            end
        end
        chk("inf_shifts", k, 4112);
        chk("inf_lap_end", bus0.lap_cnt, 8'hFF);
        chk("inf_no_done", seen_done, 0);
        chk("inf_busy", bus0.busy, 1);
        bus0.stop = 1; cyc(); bus0.stop = 0;
        chk("inf_stop", bus0.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
